// File: rtl/button_conditioner_pkg.sv
// Shared constants and pulse FSM encoding for the push-button front end.
// Imported by every button_conditioner source file.
package button_conditioner_pkg;

    localparam int NUM_BTN = 5;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } pulse_state_t;

endpackage

// File: rtl/button_conditioner_channel.sv
// One button: two-flop synchroniser, debounce filter and press/repeat
// pulse FSM.
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter bit REPEAT_ENABLE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic          s1;
    logic          s;
    logic          lvl;
    logic [DW-1:0] cnt;

    pulse_state_t  state;
    pulse_state_t  state_n;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_n;
    logic          pulse_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            lvl <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s  <= s1;
            // any return to the stable level restarts the filter
            if (s == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                lvl <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_n;
            rcnt  <= rcnt_n;
            pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        pulse_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (lvl) begin
                    pulse_n = 1'b1;
                    rcnt_n  = '0;
                    state_n = DELAY;
                end
            end
            DELAY: begin
                if (!lvl) begin
                    state_n = IDLE;
                end else if (REPEAT_ENABLE && (rcnt == RD_LAST)) begin
                    pulse_n = 1'b1;
                    rcnt_n  = '0;
                    state_n = REPEAT;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            REPEAT: begin
                // release wins over a coincident repeat expiry
                if (!lvl) begin
                    state_n = IDLE;
                end else if (rcnt == RP_LAST) begin
                    pulse_n = 1'b1;
                    rcnt_n  = '0;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign level = lvl;

endmodule

// File: rtl/button_conditioner.sv
// Five independent button channels feeding the timer FSM's B_* inputs.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter int                 REPEAT_DELAY    = 50000000,
    parameter int                 REPEAT_PERIOD   = 10000000,
    parameter logic [NUM_BTN-1:0] REPEAT_EN       = 5'b00011
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_btn_u,
    input  logic               i_btn_d,
    input  logic               i_btn_l,
    input  logic               i_btn_r,
    input  logic               i_btn_c,
    output logic               o_B_U,
    output logic               o_B_D,
    output logic               o_B_L,
    output logic               o_B_R,
    output logic               o_B_C,
    output logic [NUM_BTN-1:0] o_level
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] pulse;

    assign raw[BTN_U] = i_btn_u;
    assign raw[BTN_D] = i_btn_d;
    assign raw[BTN_L] = i_btn_l;
    assign raw[BTN_R] = i_btn_r;
    assign raw[BTN_C] = i_btn_c;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_ENABLE   (REPEAT_EN[i])
        ) u_ch (
            .clk   (i_clk),
            .rst   (i_reset),
            .raw   (raw[i]),
            .pulse (pulse[i]),
            .level (o_level[i])
        );
    end

    assign o_B_U = pulse[BTN_U];
    assign o_B_D = pulse[BTN_D];
    assign o_B_L = pulse[BTN_L];
    assign o_B_R = pulse[BTN_R];
    assign o_B_C = pulse[BTN_C];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

    logic       i_clk;
    logic       i_reset;
    logic       i_btn_u;
    logic       i_btn_d;
    logic       i_btn_l;
    logic       i_btn_r;
    logic       i_btn_c;
    logic       o_B_U;
    logic       o_B_D;
    logic       o_B_L;
    logic       o_B_R;
    logic       o_B_C;
    logic [4:0] o_level;
    logic [4:0] pulses;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .REPEAT_EN       (5'b00011)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn_u (i_btn_u),
        .i_btn_d (i_btn_d),
        .i_btn_l (i_btn_l),
        .i_btn_r (i_btn_r),
        .i_btn_c (i_btn_c),
        .o_B_U   (o_B_U),
        .o_B_D   (o_B_D),
        .o_B_L   (o_B_L),
        .o_B_R   (o_B_R),
        .o_B_C   (o_B_C),
        .o_level (o_level)
    );

    assign pulses = {o_B_C, o_B_R, o_B_L, o_B_D, o_B_U};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        {i_btn_u, i_btn_d, i_btn_l, i_btn_r, i_btn_c} = 5'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    function automatic logic [4:0] rep_u(input int e, input int last);
        return ((e == 6) || (e >= 16 && e <= last && (e - 16) % 3 == 0))
               ? 5'b00001 : 5'b00000;
    endfunction

    initial begin
        i_reset = 1'b1;
        {i_btn_u, i_btn_d, i_btn_l, i_btn_r, i_btn_c} = 5'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_level", 32'(o_level), 32'h0);
        check("rst_pulse", 32'(pulses), 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // clean press on centre, no repeat, release silent
        for (int e = 0; e < 56; e++) begin
            i_btn_c = (e < 40);
            @(posedge i_clk); #1;
            check("c_pulse", 32'(pulses), (e == 6) ? 32'h10 : 32'h0);
            check("c_level", 32'(o_level),
                  (e >= 5 && e < 45) ? 32'h10 : 32'h0);
        end

        // 2-cycle bounce on left
        do_reset();
        for (int e = 0; e < 20; e++) begin
            i_btn_l = (e < 2) || (e == 4) || (e == 5);
            @(posedge i_clk); #1;
            check("bnc_pulse", 32'(pulses), 32'h0);
            check("bnc_level", 32'(o_level), 32'h0);
        end

        // 3-cycle glitch
        do_reset();
        for (int e = 0; e < 16; e++) begin
            i_btn_l = (e < 3);
            @(posedge i_clk); #1;
            check("gl3_pulse", 32'(pulses), 32'h0);
            check("gl3_level", 32'(o_level), 32'h0);
        end

        // 4-cycle hold is just long enough
        do_reset();
        for (int e = 0; e < 20; e++) begin
            i_btn_l = (e < 4);
            @(posedge i_clk); #1;
            check("h4_pulse", 32'(pulses), (e == 6) ? 32'h4 : 32'h0);
            check("h4_level", 32'(o_level),
                  (e >= 5 && e < 9) ? 32'h4 : 32'h0);
        end

        // auto-repeat on up, held 30 cycles
        do_reset();
        for (int e = 0; e < 45; e++) begin
            i_btn_u = (e < 30);
            @(posedge i_clk); #1;
            check("rep_pulse", 32'(pulses), 32'(rep_u(e, 34)));
            check("rep_level", 32'(o_level),
                  (e >= 5 && e < 35) ? 32'h1 : 32'h0);
        end

        // release lands on the same cycle as a repeat expiry
        do_reset();
        for (int e = 0; e < 30; e++) begin
            i_btn_u = (e < 13);
            @(posedge i_clk); #1;
            check("race_pulse", 32'(pulses),
                  (e == 6 || e == 16) ? 32'h1 : 32'h0);
            check("race_level", 32'(o_level),
                  (e >= 5 && e < 18) ? 32'h1 : 32'h0);
            if (e == 19)
                check("race_idle", 32'(dut.g_ch[0].u_ch.state), 32'h0);
        end

        // simultaneous up and down
        do_reset();
        for (int e = 0; e < 20; e++) begin
            i_btn_u = (e < 10);
            i_btn_d = (e < 10);
            @(posedge i_clk); #1;
            check("sim_pulse", 32'(pulses), (e == 6) ? 32'h3 : 32'h0);
            check("sim_level", 32'(o_level),
                  (e >= 5 && e < 15) ? 32'h3 : 32'h0);
        end

        // reset while repeating, button still held
        do_reset();
        for (int e = 0; e < 20; e++) begin
            i_btn_u = 1'b1;
            @(posedge i_clk); #1;
            check("pre_pulse", 32'(pulses), 32'(rep_u(e, 19)));
        end
        i_reset = 1'b1;
        #1;
        check("mid_rst_pulse", 32'(pulses), 32'h0);
        check("mid_rst_level", 32'(o_level), 32'h0);
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int e = 0; e < 23; e++) begin
            @(posedge i_clk); #1;
            check("post_pulse", 32'(pulses), 32'(rep_u(e, 22)));
            check("post_level", 32'(o_level), (e >= 5) ? 32'h1 : 32'h0);
        end
        i_btn_u = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
